// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters and optional gshare indexing.
// IF-stage lookup and ID-stage resolution are combinational; training lands on the clock edge.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 0,
  parameter int CNT_W   = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       lookup_valid_i,
  input  logic [ADDR_W-1:0]          if_pc_i,
  output logic                       pred_taken_o,
  output logic [ADDR_W-1:0]          pred_target_o,
  output logic [$clog2(ENTRIES)-1:0] pred_idx_o,
  input  logic                       upd_valid_i,
  input  logic [ADDR_W-1:0]          upd_pc_i,
  input  logic [$clog2(ENTRIES)-1:0] upd_idx_i,
  input  logic                       upd_is_branch_i,
  input  logic                       upd_taken_i,
  input  logic [ADDR_W-1:0]          upd_target_i,
  input  logic                       upd_pred_taken_i,
  input  logic [ADDR_W-1:0]          upd_pred_target_i,
  output logic                       mispredict_o,
  output logic [ADDR_W-1:0]          redirect_pc_o,
  output logic [CNT_W-1:0]           perf_lookup_o,
  output logic [CNT_W-1:0]           perf_mispredict_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int GHR_S = (GHR_W > 0) ? GHR_W : 1;
  localparam logic [CTR_W-1:0]  CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0]  CTR_WNT = CTR_WT - CTR_W'(1);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [CTR_W-1:0]   ctr_d    [ENTRIES];
  logic [GHR_S-1:0]   ghr_q, ghr_d;
  logic [CNT_W-1:0]   perf_lookup_q, perf_lookup_d;
  logic [CNT_W-1:0]   perf_mis_q, perf_mis_d;

  logic [IDX_W-1:0]  lk_idx;
  logic              lk_hit;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_tag_match;
  logic              upd_hit;
  logic [ADDR_W-1:0] actual_pc;
  logic [ADDR_W-1:0] predicted_pc;

  // With GHR_W=0 the history term is forced to zero, giving plain bimodal indexing.
  function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_W-1:0] pc,
                                                input logic [GHR_S-1:0]  ghr);
    logic [IDX_W-1:0] hist;
    hist = (GHR_W > 0) ? IDX_W'(ghr) : '0;
    return pc[IDX_W+1:2] ^ hist;
  endfunction

  always_comb begin
    lk_idx        = index_of(if_pc_i, ghr_q);
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == if_pc_i[ADDR_W-1:IDX_W+2]);
    pred_idx_o    = lk_idx;
    pred_taken_o  = lk_hit && ctr_q[lk_idx][CTR_W-1];
    pred_target_o = pred_taken_o ? target_q[lk_idx] : if_pc_i + PC_STEP;
  end

  // Resolution is suppressed while reset is held so the discarded update never flushes.
  always_comb begin
    actual_pc     = upd_taken_i      ? upd_target_i      : upd_pc_i + PC_STEP;
    predicted_pc  = upd_pred_taken_i ? upd_pred_target_i : upd_pc_i + PC_STEP;
    mispredict_o  = !rst_i && upd_valid_i && (actual_pc != predicted_pc);
    redirect_pc_o = (!rst_i && upd_valid_i) ? actual_pc : '0;
  end

  always_comb begin
    valid_d       = valid_q;
    tag_d         = tag_q;
    target_d      = target_q;
    ctr_d         = ctr_q;
    ghr_d         = ghr_q;
    upd_tag       = upd_pc_i[ADDR_W-1:IDX_W+2];
    upd_tag_match = (tag_q[upd_idx_i] == upd_tag);
    upd_hit       = valid_q[upd_idx_i] && upd_tag_match;

    if (flush_i) begin
      valid_d = '0;
      ghr_d   = '0;
    end else if (upd_valid_i) begin
      if (upd_is_branch_i) begin
        if (upd_hit) begin
          if (upd_taken_i) begin
            if (ctr_q[upd_idx_i] != '1) ctr_d[upd_idx_i] = ctr_q[upd_idx_i] + CTR_W'(1);
            target_d[upd_idx_i] = upd_target_i;
          end else if (ctr_q[upd_idx_i] != '0) begin
            ctr_d[upd_idx_i] = ctr_q[upd_idx_i] - CTR_W'(1);
          end
        end else if (upd_taken_i) begin
          valid_d[upd_idx_i]  = 1'b1;
          tag_d[upd_idx_i]    = upd_tag;
          target_d[upd_idx_i] = upd_target_i;
          ctr_d[upd_idx_i]    = CTR_WT;
        end
        ghr_d = (GHR_W > 0) ? GHR_S'({ghr_q, upd_taken_i}) : '0;
      end else if (upd_pred_taken_i && upd_tag_match) begin
        valid_d[upd_idx_i] = 1'b0;
      end
    end
  end

  always_comb begin
    perf_lookup_d = perf_lookup_q;
    perf_mis_d    = perf_mis_q;
    if (lookup_valid_i && (perf_lookup_q != '1)) perf_lookup_d = perf_lookup_q + CNT_W'(1);
    if (mispredict_o && (perf_mis_q != '1))      perf_mis_d    = perf_mis_q + CNT_W'(1);
    perf_lookup_o     = perf_lookup_q;
    perf_mispredict_o = perf_mis_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q       <= '0;
      ghr_q         <= '0;
      perf_lookup_q <= '0;
      perf_mis_q    <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      valid_q       <= valid_d;
      ghr_q         <= ghr_d;
      perf_lookup_q <= perf_lookup_d;
      perf_mis_q    <= perf_mis_d;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: one bimodal and one gshare instance share stimulus and are
// compared against an array-based reference model of the predictor rules.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        lookup_valid;
  logic [31:0] if_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [3:0]  upd_idx0, upd_idx1;
  logic        upd_is_branch;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        pt0, pt1, mis0, mis1;
  logic [31:0] tgt0, tgt1, rd0, rd1;
  logic [3:0]  idx0, idx1;
  logic [15:0] pl0, pl1, pm0, pm1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CTR_W(2), .GHR_W(0), .CNT_W(16)) dut_bim (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .lookup_valid_i(lookup_valid), .if_pc_i(if_pc),
    .pred_taken_o(pt0), .pred_target_o(tgt0), .pred_idx_o(idx0),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_idx_i(upd_idx0),
    .upd_is_branch_i(upd_is_branch), .upd_taken_i(upd_taken), .upd_target_i(upd_target),
    .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
    .mispredict_o(mis0), .redirect_pc_o(rd0), .perf_lookup_o(pl0), .perf_mispredict_o(pm0));

  branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CTR_W(2), .GHR_W(4), .CNT_W(16)) dut_gsh (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .lookup_valid_i(lookup_valid), .if_pc_i(if_pc),
    .pred_taken_o(pt1), .pred_target_o(tgt1), .pred_idx_o(idx1),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_idx_i(upd_idx1),
    .upd_is_branch_i(upd_is_branch), .upd_taken_i(upd_taken), .upd_target_i(upd_target),
    .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
    .mispredict_o(mis1), .redirect_pc_o(rd1), .perf_lookup_o(pl1), .perf_mispredict_o(pm1));

  // Reference model: instance 0 is bimodal, instance 1 keeps 4 bits of history.
  bit          m_valid  [2][16];
  int unsigned m_tag    [2][16];
  bit [31:0]   m_target [2][16];
  int          m_ctr    [2][16];
  int unsigned m_ghr    [2];
  int unsigned m_ghr_mask[2] = '{0, 15};
  int unsigned m_plk, m_pmis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned m_idx(input int m, input bit [31:0] pc);
    return ((pc >> 2) % 16) ^ (m_ghr[m] % 16);
  endfunction

  function automatic bit [31:0] m_actual();
    return upd_taken ? upd_target : upd_pc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    bit [31:0] predicted;
    predicted = upd_pred_taken ? upd_pred_target : upd_pc + 32'd4;
    return !rst && upd_valid && (m_actual() != predicted);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ghr[m] = 0;
      for (int i = 0; i < 16; i++) begin
        m_valid[m][i] = 0;
        m_ctr[m][i]   = 1;
        m_tag[m][i]   = 0;
        m_target[m][i] = 0;
      end
    end
    m_plk  = 0;
    m_pmis = 0;
  endtask

  task automatic model_update();
    int unsigned i, tg;
    if (lookup_valid && m_plk < 65535) m_plk++;
    if (m_mispredict() && m_pmis < 65535) m_pmis++;
    for (int m = 0; m < 2; m++) begin
      if (flush) begin
        for (int e = 0; e < 16; e++) m_valid[m][e] = 0;
        m_ghr[m] = 0;
      end else if (upd_valid) begin
        i  = (m == 0) ? upd_idx0 : upd_idx1;
        tg = upd_pc >> 6;
        if (upd_is_branch) begin
          if (m_valid[m][i] && m_tag[m][i] == tg) begin
            if (upd_taken) begin
              m_ctr[m][i] = (m_ctr[m][i] < 3) ? m_ctr[m][i] + 1 : 3;
              m_target[m][i] = upd_target;
            end else begin
              m_ctr[m][i] = (m_ctr[m][i] > 0) ? m_ctr[m][i] - 1 : 0;
            end
          end else if (upd_taken) begin
            m_valid[m][i] = 1;
            m_tag[m][i] = tg;
            m_target[m][i] = upd_target;
            m_ctr[m][i] = 2;
          end
          m_ghr[m] = ((m_ghr[m] << 1) | upd_taken) & m_ghr_mask[m];
        end else if (upd_pred_taken && m_tag[m][i] == tg) begin
          m_valid[m][i] = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int unsigned i;
    bit hit, e_pt;
    bit [31:0] e_tgt;
    for (int m = 0; m < 2; m++) begin
      i = m_idx(m, if_pc);
      hit = m_valid[m][i] && (m_tag[m][i] == (if_pc >> 6));
      e_pt = !rst && hit && (m_ctr[m][i] >= 2);
      e_tgt = e_pt ? m_target[m][i] : if_pc + 32'd4;
      chk($sformatf("pred_taken[%0d]", m),  32'((m == 0) ? pt0 : pt1), 32'(e_pt));
      chk($sformatf("pred_target[%0d]", m), (m == 0) ? tgt0 : tgt1, e_tgt);
      chk($sformatf("pred_idx[%0d]", m),    32'((m == 0) ? idx0 : idx1), 32'(i));
      chk($sformatf("mispredict[%0d]", m),  32'((m == 0) ? mis0 : mis1), 32'(m_mispredict()));
      if (rst || !upd_valid)
        chk($sformatf("redirect_idle[%0d]", m), (m == 0) ? rd0 : rd1, 32'd0);
      else if (m_mispredict())
        chk($sformatf("redirect[%0d]", m), (m == 0) ? rd0 : rd1, m_actual());
      chk($sformatf("perf_lookup[%0d]", m),     32'((m == 0) ? pl0 : pl1), 32'(m_plk));
      chk($sformatf("perf_mispredict[%0d]", m), 32'((m == 0) ? pm0 : pm1), 32'(m_pmis));
    end
  endtask

  task automatic idle();
    flush = 0; lookup_valid = 0; if_pc = 32'h0; upd_valid = 0; upd_pc = 32'h0;
    upd_is_branch = 0; upd_taken = 0; upd_target = 32'h0;
    upd_pred_taken = 0; upd_pred_target = 32'h0;
  endtask

  task automatic settle();
    upd_idx0 = 4'(m_idx(0, upd_pc));
    upd_idx1 = 4'(m_idx(1, upd_pc));
    #1;
    check_outputs();
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst) model_update();
    @(negedge clk);
  endtask

  task automatic lookup(input bit [31:0] pc);
    idle();
    lookup_valid = 1; if_pc = pc;
  endtask

  task automatic branch(input bit [31:0] pc, input bit taken, input bit [31:0] tgt,
                        input bit ptaken, input bit [31:0] ptgt);
    upd_valid = 1; upd_pc = pc; upd_is_branch = 1; upd_taken = taken; upd_target = tgt;
    upd_pred_taken = ptaken; upd_pred_target = ptgt;
  endtask

  function automatic bit [31:0] rand_pc();
    return (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    idle();
    upd_idx0 = 0; upd_idx1 = 0;
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;

    // Reset state
    lookup(32'h40); settle();
    chk("rst_pt", 32'(pt0), 32'd0); chk("rst_tgt", tgt0, 32'h44); chk("rst_idx", 32'(idx0), 32'd0);
    chk("rst_plk", 32'(pl0), 32'd0); chk("rst_pmis", 32'(pm0), 32'd0);
    advance();

    // First taken branch mispredicts and allocates
    lookup(32'h40); branch(32'h40, 1, 32'h20, 0, 32'h0); settle();
    chk("alloc_mis", 32'(mis0), 32'd1); chk("alloc_redirect", rd0, 32'h20);
    advance();
    lookup(32'h40); settle();
    chk("alloc_pt", 32'(pt0), 32'd1); chk("alloc_tgt", tgt0, 32'h20);
    advance();

    // Saturation: three taken, then two not-taken
    repeat (3) begin
      lookup(32'h40); branch(32'h40, 1, 32'h20, 1, 32'h20); settle();
      chk("sat_nomis", 32'(mis0), 32'd0);
      advance();
    end
    lookup(32'h40); branch(32'h40, 0, 32'h20, 1, 32'h20); settle();
    chk("nt1_mis", 32'(mis0), 32'd1); chk("nt1_redirect", rd0, 32'h44);
    advance();
    lookup(32'h40); settle();
    chk("ctr2_pt", 32'(pt0), 32'd1); chk("ctr2_tgt", tgt0, 32'h20);
    advance();
    lookup(32'h40); branch(32'h40, 0, 32'h20, 1, 32'h20); settle();
    advance();
    lookup(32'h40); settle();
    chk("ctr1_pt", 32'(pt0), 32'd0); chk("ctr1_tgt", tgt0, 32'h44);
    advance();

    // Aliasing replaces the entry; same-cycle lookup sees pre-write contents
    lookup(32'h440); branch(32'h440, 1, 32'h100, 0, 32'h0); settle();
    chk("alias_pt", 32'(pt0), 32'd0); chk("alias_idx", 32'(idx0), 32'd0);
    advance();
    lookup(32'h40); settle();
    chk("alias_old_miss", 32'(pt0), 32'd0); chk("alias_old_tgt", tgt0, 32'h44);
    advance();

    // Flush beats a simultaneous allocating update
    lookup(32'h440); branch(32'h80, 1, 32'h200, 0, 32'h0); flush = 1; settle();
    chk("preflush_pt", 32'(pt0), 32'd1); chk("preflush_tgt", tgt0, 32'h100);
    chk("flush_mis", 32'(mis0), 32'd1);
    advance();
    lookup(32'h80); settle();
    chk("flush_noalloc", 32'(pt0), 32'd0); chk("flush_pmis", 32'(pm0), 32'd5);
    advance();
    lookup(32'h440); settle();
    chk("flush_miss", 32'(pt0), 32'd0);
    advance();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      lookup_valid    = ($urandom % 4) != 0;
      if_pc           = rand_pc();
      upd_valid       = ($urandom % 3) != 0;
      upd_pc          = rand_pc();
      upd_is_branch   = ($urandom % 4) != 0;
      upd_taken       = upd_is_branch ? 1'($urandom) : 1'b0;
      upd_target      = rand_pc() + 32'h1000;
      upd_pred_taken  = 1'($urandom);
      upd_pred_target = ($urandom % 2) ? upd_target : rand_pc();
      flush           = ($urandom % 32) == 0;
      settle();
      advance();
    end

    // Asynchronous reset in the middle of a pending update
    lookup(32'h40); branch(32'h40, 1, 32'h300, 0, 32'h0); settle();
    #2 rst = 1;
    model_reset();
    #1 check_outputs();
    chk("rstmid_mis", 32'(mis1), 32'd0);
    advance();
    settle();
    advance();
    #2 rst = 0;
    idle(); lookup(32'h40); settle();
    chk("rel_pt", 32'(pt1), 32'd0); chk("rel_idx", 32'(idx1), 32'd0);
    chk("rel_plk", 32'(pl1), 32'd0); chk("rel_pmis", 32'(pm1), 32'd0);
    advance();
    repeat (2) begin
      lookup(32'h40); branch(32'h40, 1, 32'h500, 0, 32'h0); settle();
      advance();
    end
    lookup(32'h40); settle();
    chk("gshare_idx", 32'(idx1), 32'd3); chk("bimodal_idx", 32'(idx0), 32'd0);
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipeline. It replaces static "predict not-taken, flush IF/ID on taken branch/jump" handling. The IF stage looks up the current PC in a direct-mapped branch target buffer with saturating counters and gets a predicted next PC. The ID stage reports the resolved outcome; the block returns a mispredict flag and redirect PC for the IF/ID flush, then trains its tables.

## Interface
Parameters:
- ADDR_W, 32, PC/target width
- ENTRIES, 16, table entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- CTR_W, 2, saturating counter width (≥1); MSB=1 means predict taken
- GHR_W, 0, global history bits; 0 = bimodal index, >0 = gshare index (requires GHR_W ≤ IDX_W)
- CNT_W, 16, performance counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous table invalidate
- lookup_valid_i  in  1  IF stage presents a PC this cycle
- if_pc_i  in  ADDR_W  PC being fetched
- pred_taken_o  out  1  predict taken
- pred_target_o  out  ADDR_W  predicted next PC
- pred_idx_o  out  IDX_W  index used; carried down the pipeline to ID
- upd_valid_i  in  1  ID reports a resolved instruction
- upd_pc_i  in  ADDR_W  its PC
- upd_idx_i  in  IDX_W  pred_idx_o captured at its fetch
- upd_is_branch_i  in  1  instruction is a branch or jump
- upd_taken_i  in  1  resolved taken (jumps: 1)
- upd_target_i  in  ADDR_W  resolved target
- upd_pred_taken_i  in  1  prediction made at fetch
- upd_pred_target_i  in  ADDR_W  prediction made at fetch
- mispredict_o  out  1  flush IF/ID and redirect
- redirect_pc_o  out  ADDR_W  correct next PC
- perf_lookup_o  out  CNT_W  lookup count
- perf_mispredict_o  out  CNT_W  mispredict count

## Operation
- Entry fields: valid, tag = pc[ADDR_W-1:IDX_W+2], target, ctr.
- Index: bimodal = pc[IDX_W+1:2]. Gshare = pc[IDX_W+1:2] XOR zero-extended ghr.
- Lookup (combinational):
  - hit = valid & tag match.
  - pred_taken_o = hit & ctr[CTR_W-1].
  - pred_target_o = pred_taken_o ? target : if_pc_i+4.
  - pred_idx_o is always driven, whether or not the lookup hits.
- Resolution (combinational, when upd_valid_i):
  - actual = upd_taken_i ? upd_target_i : upd_pc_i+4.
  - predicted = upd_pred_taken_i ? upd_pred_target_i : upd_pc_i+4.
  - mispredict_o = upd_valid_i & (actual != predicted).
  - redirect_pc_o = actual, and is valid only while mispredict_o=1.
  - Outside upd_valid_i: mispredict_o=0, redirect_pc_o=0.
- Training at the clock edge when upd_valid_i, always using upd_idx_i and the tag of upd_pc_i:
  - Branch, entry hit: ctr increments (taken) or decrements (not taken), saturating at 2^CTR_W-1 and 0. Target is overwritten with upd_target_i when taken.
  - Branch, entry miss, taken: allocate/replace with valid=1, tag, target, ctr = 2^(CTR_W-1) (weakly taken).
  - Branch, entry miss, not taken: no table write.
  - Non-branch with upd_pred_taken_i=1 (alias): invalidate the entry if its tag matches.
  - GHR (if GHR_W>0): shifts left by one with upd_taken_i inserted at bit 0, on every upd_is_branch_i update.
- Performance counters:
  - perf_lookup_o increments on each lookup_valid_i cycle.
  - perf_mispredict_o increments on each mispredict_o cycle.
  - Both saturate at all-ones and never wrap.
- flush_i:
  - Clears all valid bits and the GHR at the next edge. Counters and ctr values are kept.
  - flush_i with a simultaneous update: flush wins, and no entry is written or allocated. Counters still increment.

## Timing
- Lookup and resolution have zero latency (combinational from inputs).
- A table or GHR write lands on the rising edge and is visible to lookups from the next cycle. A same-cycle lookup of the index being written returns the pre-write contents.
- A simultaneous lookup and update on different indices are independent.
- Reset (asynchronous, any time including mid-update):
  - All valid=0, all ctr = 2^(CTR_W-1)-1 (weakly not taken), ghr=0, perf counters=0.
  - As a result: pred_taken_o=0, pred_target_o=if_pc_i+4, mispredict_o=0 (combinational).
  - The update pending in the reset cycle is discarded.
- No stall handshake: the pipeline must not assert upd_valid_i for a bubble or for a flushed instruction.

## Test plan
- Reset, then lookup 0x0000_0040 → pred_taken_o=0, pred_target_o=0x0000_0044, pred_idx_o=0x0 (ENTRIES=16, GHR_W=0). Both perf counters read 0.
- Taken branch at 0x40 → target 0x20, predicted not taken:
  - Same cycle: mispredict_o=1, redirect_pc_o=0x20.
  - Next-cycle lookup 0x40: pred_taken_o=1, pred_target_o=0x20.
  - Stored ctr = 2.
- Counter saturation: three more taken updates at 0x40 → ctr=3. Then one not-taken → ctr=2, still predicts taken. A second not-taken → ctr=1, lookup 0x40 gives pred_target_o=0x44.
- Aliasing: PC 0x440 (same index as 0x40, different tag) → lookup miss. A taken update at 0x440 → 0x100 replaces the entry, and lookup 0x40 then misses.
- flush_i asserted in the same cycle as a taken update at 0x80:
  - Next cycle: all lookups miss, entry at 0x80 not allocated.
  - perf_mispredict_o incremented once.
- Gshare (GHR_W=4), async reset asserted mid-cycle during an update:
  - After release: ghr=0, counters=0, lookup miss.
  - Then two taken updates: ghr=0b0011, and the lookup index for 0x40 is 0x0 XOR 0x3 = 0x3.
